// File: rtl/bsg_cache_pkt_decode_pipe.sv
// Registered cache-packet decoder: accepts packets over valid/ready, presents packet plus decoded
// control bundle over valid/yumi one cycle later, and counts accepted illegal opcodes.
module bsg_cache_pkt_decode_pipe #(
   parameter  int addr_width_p    = 28,
   parameter  int data_width_p    = 32,
   parameter  int err_cnt_width_p = 8,
   localparam int mask_width_lp   = data_width_p / 8,
   localparam int pkt_width_lp    = 5 + addr_width_p + data_width_p + mask_width_lp
) (
   input  logic                       clk_i,
   input  logic                       reset_n_i,
   input  logic                       v_i,
   input  logic [pkt_width_lp-1:0]    cache_pkt_i,
   output logic                       ready_o,
   output logic                       v_o,
   output logic [pkt_width_lp-1:0]    cache_pkt_o,
   input  logic                       yumi_i,
   output logic [1:0]                 size_op_o,
   output logic                       sigext_o,
   output logic                       ld_o,
   output logic                       st_o,
   output logic                       mask_op_o,
   output logic [3:0]                 tag_op_o,
   output logic [4:0]                 maint_op_o,
   output logic                       illegal_o,
   input  logic                       err_clear_i,
   output logic [err_cnt_width_p-1:0] err_cnt_o
);

   localparam bit       dword_ok_lp = (data_width_p >= 64);
   localparam logic [1:0] sm_size_lp = (data_width_p >= 64) ? 2'd3 : 2'd2;

   logic [4:0] opcode;
   logic       accept;

   logic [1:0] dec_size;
   logic       dec_sigext, dec_ld, dec_st, dec_mask, dec_illegal;
   logic [3:0] dec_tag;
   logic [4:0] dec_maint;

   logic                       v_q, v_d;
   logic [pkt_width_lp-1:0]    pkt_q, pkt_d;
   logic [1:0]                 size_op_q, size_op_d;
   logic                       sigext_q, sigext_d;
   logic                       ld_q, ld_d;
   logic                       st_q, st_d;
   logic                       mask_op_q, mask_op_d;
   logic [3:0]                 tag_op_q, tag_op_d;
   logic [4:0]                 maint_op_q, maint_op_d;
   logic                       illegal_q, illegal_d;
   logic [err_cnt_width_p-1:0] err_cnt_q, err_cnt_d;

   assign opcode  = cache_pkt_i[pkt_width_lp-1 -: 5];
   assign ready_o = ~v_q | yumi_i;
   assign accept  = v_i & ready_o;

   // Doubleword-only opcodes fall through to illegal on a 32-bit datapath.
   always_comb begin
      dec_size    = 2'd0;
      dec_sigext  = 1'b0;
      dec_ld      = 1'b0;
      dec_st      = 1'b0;
      dec_mask    = 1'b0;
      dec_tag     = 4'd0;
      dec_maint   = 5'd0;
      dec_illegal = 1'b0;
      case (opcode)
         5'h00, 5'h01, 5'h02: begin
            dec_ld     = 1'b1;
            dec_size   = opcode[1:0];
            dec_sigext = 1'b1;
         end
         5'h03: begin
            if (dword_ok_lp) begin
               dec_ld     = 1'b1;
               dec_size   = 2'd3;
               dec_sigext = 1'b1;
            end else begin
               dec_illegal = 1'b1;
            end
         end
         5'h04, 5'h05: begin
            dec_ld   = 1'b1;
            dec_size = opcode[1:0];
         end
         5'h06: begin
            if (dword_ok_lp) begin
               dec_ld   = 1'b1;
               dec_size = opcode[1:0];
            end else begin
               dec_illegal = 1'b1;
            end
         end
         5'h08, 5'h09, 5'h0A: begin
            dec_st   = 1'b1;
            dec_size = opcode[1:0];
         end
         5'h0B: begin
            if (dword_ok_lp) begin
               dec_st   = 1'b1;
               dec_size = 2'd3;
            end else begin
               dec_illegal = 1'b1;
            end
         end
         5'h0C: begin
            dec_st   = 1'b1;
            dec_mask = 1'b1;
            dec_size = sm_size_lp;
         end
         5'h10, 5'h11, 5'h12, 5'h13: dec_tag = 4'b0001 << opcode[1:0];
         5'h18, 5'h19, 5'h1A, 5'h1B, 5'h1C: dec_maint = 5'b00001 << opcode[2:0];
         default: dec_illegal = 1'b1;
      endcase
   end

   always_comb begin
      v_d        = v_q;
      pkt_d      = pkt_q;
      size_op_d  = size_op_q;
      sigext_d   = sigext_q;
      ld_d       = ld_q;
      st_d       = st_q;
      mask_op_d  = mask_op_q;
      tag_op_d   = tag_op_q;
      maint_op_d = maint_op_q;
      illegal_d  = illegal_q;
      err_cnt_d  = err_cnt_q;
      if (accept) begin
         v_d        = 1'b1;
         pkt_d      = cache_pkt_i;
         size_op_d  = dec_size;
         sigext_d   = dec_sigext;
         ld_d       = dec_ld;
         st_d       = dec_st;
         mask_op_d  = dec_mask;
         tag_op_d   = dec_tag;
         maint_op_d = dec_maint;
         illegal_d  = dec_illegal;
      end else if (yumi_i) begin
         v_d = 1'b0;
      end
      // Clear wins over a same-cycle increment; the count sticks at all-ones.
      if (err_clear_i) begin
         err_cnt_d = '0;
      end else if (accept && dec_illegal && !(&err_cnt_q)) begin
         err_cnt_d = err_cnt_q + err_cnt_width_p'(1);
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         v_q        <= 1'b0;
         pkt_q      <= '0;
         size_op_q  <= 2'd0;
         sigext_q   <= 1'b0;
         ld_q       <= 1'b0;
         st_q       <= 1'b0;
         mask_op_q  <= 1'b0;
         tag_op_q   <= 4'd0;
         maint_op_q <= 5'd0;
         illegal_q  <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         v_q        <= v_d;
         pkt_q      <= pkt_d;
         size_op_q  <= size_op_d;
         sigext_q   <= sigext_d;
         ld_q       <= ld_d;
         st_q       <= st_d;
         mask_op_q  <= mask_op_d;
         tag_op_q   <= tag_op_d;
         maint_op_q <= maint_op_d;
         illegal_q  <= illegal_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign v_o         = v_q;
   assign cache_pkt_o = pkt_q;
   assign size_op_o   = size_op_q;
   assign sigext_o    = sigext_q;
   assign ld_o        = ld_q;
   assign st_o        = st_q;
   assign mask_op_o   = mask_op_q;
   assign tag_op_o    = tag_op_q;
   assign maint_op_o  = maint_op_q;
   assign illegal_o   = illegal_q;
   assign err_cnt_o   = err_cnt_q;

   yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);

endmodule

// File: tb/tb_bsg_cache_pkt_decode_pipe.sv
// Drives a 32-bit and a 64-bit (2-bit error counter) decoder with shared handshakes and compares
// both against an opcode-table model every cycle, plus directed literal checks.
module tb_bsg_cache_pkt_decode_pipe;

   localparam int PW32 = 5 + 28 + 32 + 4;
   localparam int PW64 = 5 + 28 + 64 + 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rstN = 1'b0;
   logic vI = 1'b0, yumiI = 1'b0, clrI = 1'b0;
   logic [PW32-1:0] pktIn32 = '0;
   logic [PW64-1:0] pktIn64 = '0;

   logic            ready32, v32, sigext32, ld32, st32, mask32, illegal32;
   logic [PW32-1:0] pktOut32;
   logic [1:0]      size32;
   logic [3:0]      tag32;
   logic [4:0]      maint32;
   logic [7:0]      err32;

   logic            ready64, v64, sigext64, ld64, st64, mask64, illegal64;
   logic [PW64-1:0] pktOut64;
   logic [1:0]      size64;
   logic [3:0]      tag64;
   logic [4:0]      maint64;
   logic [1:0]      err64;

   bsg_cache_pkt_decode_pipe #(.addr_width_p(28), .data_width_p(32), .err_cnt_width_p(8)) u32 (
      .clk_i(clk), .reset_n_i(rstN), .v_i(vI), .cache_pkt_i(pktIn32), .ready_o(ready32),
      .v_o(v32), .cache_pkt_o(pktOut32), .yumi_i(yumiI), .size_op_o(size32), .sigext_o(sigext32),
      .ld_o(ld32), .st_o(st32), .mask_op_o(mask32), .tag_op_o(tag32), .maint_op_o(maint32),
      .illegal_o(illegal32), .err_clear_i(clrI), .err_cnt_o(err32));

   bsg_cache_pkt_decode_pipe #(.addr_width_p(28), .data_width_p(64), .err_cnt_width_p(2)) u64 (
      .clk_i(clk), .reset_n_i(rstN), .v_i(vI), .cache_pkt_i(pktIn64), .ready_o(ready64),
      .v_o(v64), .cache_pkt_o(pktOut64), .yumi_i(yumiI), .size_op_o(size64), .sigext_o(sigext64),
      .ld_o(ld64), .st_o(st64), .mask_op_o(mask64), .tag_op_o(tag64), .maint_op_o(maint64),
      .illegal_o(illegal64), .err_clear_i(clrI), .err_cnt_o(err64));

   typedef struct packed {
      logic [1:0] size;
      logic       sigext;
      logic       ld;
      logic       st;
      logic       maskOp;
      logic [3:0] tag;
      logic [4:0] maint;
      logic       illegal;
   } dec_t;

   int assertCount = 0;
   int failCount   = 0;
   bit checkEn     = 1'b0;

   // Opcode table: classify by range, then derive each field from the opcode's meaning.
   function automatic dec_t modelDecode(int op, bit is64);
      dec_t d;
      bit isLoad, isStore, isTag, isMaint, dwOnly;
      d       = '0;
      isLoad  = (op >= 0)  && (op <= 6);
      isStore = (op >= 8)  && (op <= 12);
      isTag   = (op >= 16) && (op <= 19);
      isMaint = (op >= 24) && (op <= 28);
      dwOnly  = (op == 3) || (op == 6) || (op == 11);
      if (!(isLoad || isStore || isTag || isMaint) || (dwOnly && !is64)) begin
         d.illegal = 1'b1;
         return d;
      end
      if (isLoad || isStore) d.size = (op == 12) ? (is64 ? 2'd3 : 2'd2) : 2'(op % 4);
      d.sigext = (op <= 3);
      d.ld     = isLoad;
      d.st     = isStore;
      d.maskOp = (op == 12);
      if (isTag)   d.tag   = 4'(1 << (op - 16));
      if (isMaint) d.maint = 5'(1 << (op - 24));
      return d;
   endfunction

   bit              modV = 1'b0;
   bit              modAcc;
   logic [PW32-1:0] modPkt32 = '0;
   logic [PW64-1:0] modPkt64 = '0;
   dec_t            modDec32 = '0, modDec64 = '0, newDec32, newDec64;
   int              modCnt32 = 0, modCnt64 = 0;

   // Reference pipeline: one held transaction plus two saturating counters.
   always @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         modV     = 1'b0;
         modPkt32 = '0;
         modPkt64 = '0;
         modDec32 = '0;
         modDec64 = '0;
         modCnt32 = 0;
         modCnt64 = 0;
      end else begin
         modAcc   = vI && (!modV || yumiI);
         newDec32 = modelDecode(int'(pktIn32[PW32-1 -: 5]), 1'b0);
         newDec64 = modelDecode(int'(pktIn64[PW64-1 -: 5]), 1'b1);
         if (clrI) begin
            modCnt32 = 0;
            modCnt64 = 0;
         end else if (modAcc) begin
            if (newDec32.illegal && modCnt32 < 255) modCnt32++;
            if (newDec64.illegal && modCnt64 < 3)   modCnt64++;
         end
         if (modAcc) begin
            modV     = 1'b1;
            modPkt32 = pktIn32;
            modPkt64 = pktIn64;
            modDec32 = newDec32;
            modDec64 = newDec64;
         end else if (yumiI) begin
            modV = 1'b0;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, sampled on the falling edge.
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("v32", v32, modV);
         checkOutput("v64", v64, modV);
         checkOutput("ready32", ready32, !modV || yumiI);
         checkOutput("ready64", ready64, !modV || yumiI);
         checkOutput("errCnt32", err32, modCnt32);
         checkOutput("errCnt64", err64, modCnt64);
         if (modV) begin
            checkOutput("pkt32", pktOut32, modPkt32);
            checkOutput("pkt64", pktOut64, modPkt64);
            checkOutput("dec32", {size32, sigext32, ld32, st32, mask32, tag32, maint32, illegal32}, modDec32);
            checkOutput("dec64", {size64, sigext64, ld64, st64, mask64, tag64, maint64, illegal64}, modDec64);
         end
      end
   end

   task automatic applyStimulus(input bit v, input int op, input bit y, input bit clr);
      vI      = v;
      yumiI   = y && modV;
      clrI    = clr;
      pktIn32 = {5'(op), 28'($urandom), 32'($urandom), 4'($urandom)};
      pktIn64 = {5'(op), 28'($urandom), 32'($urandom), 32'($urandom), 8'($urandom)};
      @(posedge clk);
      #1;
   endtask

   task automatic resetPulse();
      @(negedge clk);
      #1;
      rstN  = 1'b0;
      vI    = 1'b0;
      yumiI = 1'b0;
      clrI  = 1'b0;
      #1;
      checkOutput("rstV32", v32, 1'b0);
      checkOutput("rstV64", v64, 1'b0);
      checkOutput("rstReady32", ready32, 1'b1);
      checkOutput("rstErr64", err64, 2'd0);
      @(negedge clk);
      #1;
      rstN = 1'b1;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      checkOutput("resetReady32", ready32, 1'b1);
      checkOutput("resetReady64", ready64, 1'b1);
      checkOutput("resetV32", v32, 1'b0);
      checkOutput("resetErr32", err32, 8'd0);
      checkEn = 1'b1;
      #1;
      rstN = 1'b1;

      applyStimulus(1, 'h00, 0, 0);
      checkOutput("lbV", v32, 1'b1);
      checkOutput("lbSize", size32, 2'd0);
      checkOutput("lbSigext", sigext32, 1'b1);
      checkOutput("lbLd", ld32, 1'b1);
      checkOutput("lbIllegal", illegal32, 1'b0);

      applyStimulus(1, 'h02, 1, 0);
      checkOutput("lwSize", size32, 2'd2);
      checkOutput("lwSigext", sigext32, 1'b1);
      applyStimulus(1, 'h0A, 1, 0);
      checkOutput("swSt", st32, 1'b1);
      applyStimulus(1, 'h0C, 1, 0);
      checkOutput("smMask", mask32, 1'b1);
      checkOutput("smSize", size32, 2'd2);
      applyStimulus(1, 'h13, 1, 0);
      checkOutput("taglaTag", tag32, 4'b1000);

      applyStimulus(1, 'h05, 1, 0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 'h08, 0, 0);
         checkOutput("bpReady", ready32, 1'b0);
         checkOutput("bpSize", size32, 2'd1);
         checkOutput("bpSigext", sigext32, 1'b0);
         checkOutput("bpLd", ld32, 1'b1);
      end
      applyStimulus(1, 'h08, 1, 0);
      checkOutput("sbSt", st32, 1'b1);
      checkOutput("sbSize", size32, 2'd0);

      applyStimulus(1, 'h03, 1, 0);
      checkOutput("ld32Illegal", illegal32, 1'b1);
      checkOutput("ld32Fields", {size32, sigext32, ld32, st32, mask32, tag32, maint32}, 15'd0);
      checkOutput("ld32Err", err32, 8'd1);
      checkOutput("ld64Size", size64, 2'd3);
      checkOutput("ld64Sigext", sigext64, 1'b1);
      checkOutput("ld64Illegal", illegal64, 1'b0);
      applyStimulus(1, 'h1F, 1, 0);
      checkOutput("op1fIllegal", illegal32, 1'b1);
      checkOutput("op1fErr", err32, 8'd2);
      applyStimulus(1, 'h0C, 1, 0);
      checkOutput("sm64Size", size64, 2'd3);

      for (int i = 0; i < 5; i++) applyStimulus(1, 'h1F, 1, 0);
      checkOutput("satErr64", err64, 2'd3);
      checkOutput("satErr32", err32, 8'd7);
      applyStimulus(1, 'h1F, 1, 1);
      checkOutput("clrErr64", err64, 2'd0);
      checkOutput("clrErr32", err32, 8'd0);

      resetPulse();

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) resetPulse();
         applyStimulus($urandom_range(0, 3) != 0, int'($urandom_range(0, 31)),
                       $urandom_range(0, 1) == 1, $urandom_range(0, 39) == 0);
      end
      applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/bsg_cache_pkt_decode_pipe.md
Name: bsg_cache_pkt_decode_pipe

Overview:
- Registered, flow-controlled successor to the combinational cache-packet decoder.
- Accepts cache packets over valid/ready, decodes the opcode into a control bundle, and presents packet plus decode over valid/yumi. The decode is registered in one pipeline stage.
- Generalised over address/data width. Doubleword ops are legal only when data_width_p>=64.
- Adds illegal-opcode detection and a saturating error counter. Sits between the cache request port and the tag-lookup stage.

Parameters:
- addr_width_p, 28, address field width.
- data_width_p, 32, data field width; must be 32 or 64.
- mask_width_lp, data_width_p/8, byte-mask width (derived, not overridable).
- pkt_width_lp, 5+addr_width_p+data_width_p+mask_width_lp, packet width (derived).
- err_cnt_width_p, 8, width of the illegal-op counter.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- v_i  in  1  input packet valid
- cache_pkt_i  in  pkt_width_lp  packet {opcode[4:0], addr, data, mask}, opcode in the MSBs
- ready_o  out  1  stage can accept
- v_o  out  1  output valid
- cache_pkt_o  out  pkt_width_lp  registered packet
- yumi_i  in  1  consumer takes output; legal only when v_o=1
- size_op_o  out  2  log2 bytes: 0=B, 1=H, 2=W, 3=D
- sigext_o  out  1  sign-extend load
- ld_o  out  1  load
- st_o  out  1  store
- mask_op_o  out  1  masked store, uses mask
- tag_op_o  out  4  one-hot {TAGLA, TAGLV, TAGFL, TAGST}
- maint_op_o  out  5  one-hot {AUNLOCK, ALOCK, AINV, AFLINV, AFL}
- illegal_o  out  1  opcode unsupported
- err_clear_i  in  1  synchronous clear of the counter
- err_cnt_o  out  err_cnt_width_p  saturating count of accepted illegal packets

Behaviour:
- Opcode map (hex):
  - Loads: 00 LB, 01 LH, 02 LW, 03 LD, 04 LBU, 05 LHU, 06 LWU.
  - Stores: 08 SB, 09 SH, 0A SW, 0B SD, 0C SM.
  - Tag ops: 10 TAGST, 11 TAGFL, 12 TAGLV, 13 TAGLA.
  - Maintenance: 18 AFL, 19 AFLINV, 1A AINV, 1B ALOCK, 1C AUNLOCK.
- Illegal opcodes: all other codes. When data_width_p=32, LD, LWU and SD are also illegal.
- Decode rules:
  - size_op = opcode[1:0] for loads/stores. SM gives size_op = log2(mask_width_lp).
  - sigext=1 for LB/LH/LW/LD only.
  - Illegal opcode: every decode output is 0 and illegal_o=1.
  - Exactly one of ld/st/tag/maint is set for any legal opcode.
- Pipeline:
  - Single register stage; ready_o = ~v_o | yumi_i, combinational.
  - Transfer in when v_i & ready_o. Next cycle: v_o=1, and packet plus decode reflect that input.
  - Latency 1 cycle; full throughput (back-to-back accepts with yumi_i held high).
  - yumi_i without a new accept: v_o goes to 0 next cycle. Output register contents are don't-care but held.
  - v_o=1 & ~yumi_i: outputs held stable, ready_o=0, the input is not sampled.
- Counter:
  - Increments by 1 on the accept (input handshake) of an illegal packet. Saturates at all-ones with no wrap.
  - err_clear_i has priority over an increment in the same cycle: result is 0.
- Reset: asynchronous assertion, synchronous-release clocking assumed.
  - Values: v_o=0, err_cnt_o=0, all registered decode/packet outputs 0, so ready_o=1 while in reset.
  - Reset mid-transfer drops the held packet with no replay.
- Illegal packets still flow to the output (flagged); the block never stalls on them.
- Behaviour for yumi_i while v_o=0 is undefined. An assertion fires in simulation.

Test Plan:
- Reset release, data_width_p=32: v_i=1, opcode 00 LB -> next cycle v_o=1, size_op=0, sigext=1, ld=1, illegal=0; ready_o=1 at reset.
- Stream 02, 0A, 0C, 13 with yumi_i=1 -> one output per cycle in order.
  - LW: size=2, sigext=1.
  - SW: st=1.
  - SM: mask_op=1, size=2.
  - TAGLA: tag_op=4'b1000.
- Backpressure: accept LHU (05), hold yumi_i=0 for 3 cycles while v_i=1 with SB -> ready_o=0 throughout, outputs stable with size=1 and sigext=0. Assert yumi_i -> SB appears on the next cycle.
- data_width_p=32: opcode 03 then 1F -> both illegal_o=1 with all decode fields 0; err_cnt_o goes 0->1->2.
- data_width_p=64: opcode 03 -> size_op=3, sigext=1, illegal=0. Opcode 0C -> size_op=3.
- err_cnt_width_p=2: 5 illegal accepts -> err_cnt_o saturates at 3. err_clear_i asserted with a concurrent illegal accept -> 0. Asserting reset_n_i low while v_o=1 -> v_o=0 immediately.
